// File: rtl/divq_bcd_if.sv
// Handshake and result bus between the divider and the BCD converter.
interface divq_bcd_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     quotient;
  logic [DATA_W-1:0]     remainder;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   q_bcd;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [1:0]            q_digits;

  // Upstream/consumer side: drives the input pair and the output acceptance.
  modport master (
    output in_valid, quotient, remainder, out_ready,
    input  in_ready, out_valid, q_bcd, r_bcd, q_digits
  );

  // Converter side.
  modport slave (
    input  in_valid, quotient, remainder, out_ready,
    output in_ready, out_valid, q_bcd, r_bcd, q_digits
  );
endinterface

// File: rtl/divq_bcd_converter.sv
// Sequential double-dabble converter for the divider's quotient and remainder.
// One binary bit is consumed per cycle; both operands convert in lockstep.
module divq_bcd_converter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic      clk,
  input  logic      rst,
  divq_bcd_if.slave bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One add-3 / shift-left step over a {bcd, bin} pair.
  function automatic logic [BCD_W+DATA_W-1:0] dabble(input logic [BCD_W-1:0]  bcd,
                                                     input logic [DATA_W-1:0] bin);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj, bin} << 1;
  endfunction

  // Highest non-zero digit index + 1; a zero value still counts as one digit.
  function automatic logic [1:0] sig_digits(input logic [BCD_W-1:0] bcd);
    logic [1:0] n;
    n = 2'd1;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) n = 2'(i + 1);
    end
    return n;
  endfunction

  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [DATA_W-1:0]  q_bin_q,     q_bin_d;
  logic [DATA_W-1:0]  r_bin_q,     r_bin_d;
  logic [BCD_W-1:0]   q_acc_q,     q_acc_d;
  logic [BCD_W-1:0]   r_acc_q,     r_acc_d;
  logic [BCD_W-1:0]   q_bcd_q,     q_bcd_d;
  logic [BCD_W-1:0]   r_bcd_q,     r_bcd_d;
  logic [1:0]         q_digits_q,  q_digits_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [BCD_W-1:0]   q_acc_nx, r_acc_nx;
  logic [DATA_W-1:0]  q_bin_nx, r_bin_nx;

  assign {q_acc_nx, q_bin_nx} = dabble(q_acc_q, q_bin_q);
  assign {r_acc_nx, r_bin_nx} = dabble(r_acc_q, r_bin_q);

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_bin_d    = q_bin_q;
    r_bin_d    = r_bin_q;
    q_acc_d    = q_acc_q;
    r_acc_d    = r_acc_q;
    q_bcd_d    = q_bcd_q;
    r_bcd_d    = r_bcd_q;
    q_digits_d = q_digits_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          q_bin_d = bus.quotient;
          r_bin_d = bus.remainder;
          q_acc_d = '0;
          r_acc_d = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        q_bin_d = q_bin_nx;
        r_bin_d = r_bin_nx;
        q_acc_d = q_acc_nx;
        r_acc_d = r_acc_nx;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          q_bcd_d    = q_acc_nx;
          r_bcd_d    = r_acc_nx;
          q_digits_d = sig_digits(q_acc_nx);
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      q_bin_q     <= '0;
      r_bin_q     <= '0;
      q_acc_q     <= '0;
      r_acc_q     <= '0;
      q_bcd_q     <= '0;
      r_bcd_q     <= '0;
      q_digits_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_bin_q     <= q_bin_d;
      r_bin_q     <= r_bin_d;
      q_acc_q     <= q_acc_d;
      r_acc_q     <= r_acc_d;
      q_bcd_q     <= q_bcd_d;
      r_bcd_q     <= r_bcd_d;
      q_digits_q  <= q_digits_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.q_bcd     = q_bcd_q;
  assign bus.r_bcd     = r_bcd_q;
  assign bus.q_digits  = q_digits_q;

endmodule
